mvm_param: RTL

Parametrised, handshaked signed matrix-vector multiplier computing y = M·x for an N×N matrix M and an N-element vector x. Operands arrive as one signed word per transfer on a valid/ready input stream; results leave as one signed word per transfer on a valid/ready output stream. Each result carries an overflow flag. This block generalises the fixed 3×3 multiplier with:
- a configurable dimension and configurable input/output widths;
- a saturating output mode;
- a matrix-reuse mode, so that consecutive vectors can be sent without reloading M.

---
 rtl/mvm_param.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mvm_param.sv
// rtl/mvm_param.sv - Handshaked signed N x N matrix-vector multiplier with matrix reuse and optional saturation
module mvm_param #(
  parameter int N   = 3,
  parameter int IW  = 8,
  parameter int OW  = 16,
  parameter int SAT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [IW-1:0] data_in,
  input  logic          reuse_matrix,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] data_out,
  output logic          overflow
);

  localparam int MW = $clog2(N*N+1);
  localparam int CW = $clog2(N+1);
  localparam logic [MW-1:0] M_LAST = MW'(N*N-1);
  localparam logic [CW-1:0] V_LAST = CW'(N-1);
  localparam logic signed [OW-1:0] ACC_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] ACC_MIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {LOAD_M, LOAD_X, MAC, OUT} state_t;

  state_t state, state_nxt;

  logic                 run;
  logic                 mat_loaded;
  logic [MW-1:0]        mcnt;
  logic [MW-1:0]        mptr;
  logic [CW-1:0]        xcnt;
  logic [CW-1:0]        row;
  logic [CW-1:0]        col;
  logic signed [OW-1:0] acc;
  logic                 acc_ovf;

  // Arrays are padded to a power of two so counter-width indices always fit.
  logic [IW-1:0] m_mem [2**MW];
  logic [IW-1:0] x_mem [2**CW];

  logic s_fire;
  logic m_fire;
  logic reuse_start;

  logic signed [2*IW-1:0] m_ext;
  logic signed [2*IW-1:0] x_ext;
  logic signed [2*IW-1:0] prod;
  logic signed [OW-1:0]   prod_ext;
  logic signed [OW-1:0]   sum;
  logic signed [OW-1:0]   acc_nxt;
  logic                   add_ovf;
  logic                   ovf_nxt;

  assign s_fire      = s_valid && s_ready;
  assign m_fire      = m_valid && m_ready;
  assign reuse_start = s_fire && (state == LOAD_M) && (mcnt == '0) && reuse_matrix && mat_loaded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD_M;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_M: if (s_fire && (reuse_start || mcnt == M_LAST)) state_nxt = LOAD_X;
      LOAD_X: if (s_fire && xcnt == V_LAST) state_nxt = MAC;
      MAC:    if (col == V_LAST) state_nxt = OUT;
      OUT:    if (m_fire) state_nxt = (row == V_LAST) ? LOAD_M : MAC;
      default: state_nxt = LOAD_M;
    endcase
  end

  // run holds s_ready low until the first edge after reset release.
  always_comb begin
    s_ready = run && ((state == LOAD_M) || (state == LOAD_X));
    m_valid = (state == OUT);
  end

  always_comb begin
    m_ext    = (2*IW)'($signed(m_mem[mptr]));
    x_ext    = (2*IW)'($signed(x_mem[col]));
    prod     = m_ext * x_ext;
    prod_ext = OW'(prod);
    sum      = acc + prod_ext;
    add_ovf  = (acc[OW-1] == prod_ext[OW-1]) && (sum[OW-1] != acc[OW-1]);
    acc_nxt  = sum;
    if (SAT != 0 && add_ovf) acc_nxt = acc[OW-1] ? ACC_MIN : ACC_MAX;
    ovf_nxt  = acc_ovf | add_ovf;
  end

  always_ff @(posedge clk) begin
    if (s_fire && state == LOAD_M) begin
      if (reuse_start) x_mem[0] <= data_in;
      else             m_mem[mcnt] <= data_in;
    end
    if (s_fire && state == LOAD_X) x_mem[xcnt] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run        <= 1'b0;
      mat_loaded <= 1'b0;
      mcnt       <= '0;
      mptr       <= '0;
      xcnt       <= '0;
      row        <= '0;
      col        <= '0;
      acc        <= '0;
      acc_ovf    <= 1'b0;
      data_out   <= '0;
      overflow   <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        LOAD_M: if (s_fire) begin
          if (reuse_start) begin
            xcnt <= CW'(1);
          end else if (mcnt == M_LAST) begin
            mcnt       <= '0;
            mat_loaded <= 1'b1;
          end else begin
            mcnt <= mcnt + MW'(1);
          end
        end
        LOAD_X: if (s_fire) begin
          if (xcnt == V_LAST) begin
            xcnt    <= '0;
            row     <= '0;
            col     <= '0;
            mptr    <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
          end else begin
            xcnt <= xcnt + CW'(1);
          end
        end
        // mptr walks M row-major across all rows, so it never needs reloading between rows.
        MAC: begin
          acc     <= acc_nxt;
          acc_ovf <= ovf_nxt;
          mptr    <= mptr + MW'(1);
          if (col == V_LAST) begin
            col      <= '0;
            data_out <= acc_nxt;
            overflow <= ovf_nxt;
          end else begin
            col <= col + CW'(1);
          end
        end
        OUT: if (m_fire) begin
          acc     <= '0;
          acc_ovf <= 1'b0;
          row     <= (row == V_LAST) ? '0 : row + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
